// File: rtl/video_pkg.sv
// video_pkg: shared FSM states, tdata field layout and pixel helpers for the DVP capture path
package video_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DROP} state_t;

    localparam int R_HI = 23, R_LO = 16;
    localparam int B_HI = 15, B_LO = 8;
    localparam int G_HI = 7,  G_LO = 0;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [23:0] tdata;
    } fifo_entry_t;

    // Replicate the MSBs into the new LSBs so full-scale stays full-scale
    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
        logic [23:0] t;
        t = '0;
        t[R_HI:R_LO] = {p[15:11], p[15:13]};
        t[B_HI:B_LO] = {p[4:0], p[4:2]};
        t[G_HI:G_LO] = {p[10:5], p[10:9]};
        return t;
    endfunction

endpackage

// File: rtl/dvp_rgb565_axis_capture_if.sv
// dvp_rgb565_axis_capture_if: AXI4-Stream video bus carrying RGB888 pixels with SOF/EOL markers
interface dvp_rgb565_axis_capture_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through FIFO; a push at full succeeds when a pop coincides
module axis_sync_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign full    = cnt == FULL_CNT;
    assign empty   = cnt == '0;
    assign rdata   = mem[rp];

    always_ff @(posedge aclk)
        if (do_push) mem[wp] <= wdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/dvp_rgb565_axis_capture.sv
// dvp_rgb565_axis_capture: pairs DVP RGB565 bytes into pixels and streams them as RGB888 AXI4-Stream video
module dvp_rgb565_axis_capture
    import video_pkg::*;
#(
    parameter int ACTIVE_W   = 640,
    parameter int ACTIVE_H   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        en_capture,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    dvp_rgb565_axis_capture_if.master m_axis_video,
    output logic        overflow,
    output logic        line_err,
    output logic [15:0] frame_cnt
);
    localparam int PW = $clog2(ACTIVE_W + 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(ACTIVE_W - 1);
    localparam logic [PW-1:0] LINE_FULL = PW'(ACTIVE_W);

    if (ACTIVE_W < 2 || ACTIVE_H < 1 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("dvp_rgb565_axis_capture: invalid parameters");
    end

    state_t      state, state_n;
    logic        vs_r, vs_q, hr_r, hr_q, phase, sof_pending;
    logic [7:0]  d_r, hi;
    logic [PW-1:0] pix_cnt;
    logic        vs_rise, vs_fall, hr_fall, cap, pix_done, push, pop, full, empty;
    logic        ovf_now, lerr_now, flag_clr;
    fifo_entry_t wr, rd;

    assign vs_rise  = vs_r & ~vs_q;
    assign vs_fall  = ~vs_r & vs_q;
    assign hr_fall  = ~hr_r & hr_q;
    assign cap      = state == ACTIVE && hr_r;
    assign pix_done = cap & phase;
    assign pop      = ~empty & m_axis_video.tready;
    assign push     = pix_done & (~full | pop);
    assign ovf_now  = pix_done & full & ~pop;
    // Odd trailing byte, wrong pixel count, or a line cut short by vsync all count as line errors
    assign lerr_now = state == ACTIVE && ((hr_fall && (pix_cnt != LINE_FULL || phase)) || (vs_rise && hr_r));
    assign flag_clr = state == IDLE && state_n == WAIT_FRAME;
    assign wr       = '{tuser: sof_pending, tlast: pix_cnt == LAST_PIX, tdata: rgb565_to_rgb888({hi, d_r})};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = en_capture ? WAIT_FRAME : IDLE;
            WAIT_FRAME: state_n = !en_capture ? IDLE : vs_fall ? ACTIVE : WAIT_FRAME;
            default:    state_n = vs_rise ? (en_capture ? WAIT_FRAME : IDLE) : ovf_now ? DROP : state;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            vs_r        <= 1'b0;
            vs_q        <= 1'b0;
            hr_r        <= 1'b0;
            hr_q        <= 1'b0;
            d_r         <= '0;
            hi          <= '0;
            phase       <= 1'b0;
            sof_pending <= 1'b0;
            pix_cnt     <= '0;
            overflow    <= 1'b0;
            line_err    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            vs_r        <= vsync;
            vs_q        <= vs_r;
            hr_r        <= href;
            hr_q        <= hr_r;
            d_r         <= din;
            // Phase drops to 0 whenever href is low, so every line starts on a high byte
            phase       <= cap & ~phase;
            if (cap && !phase) hi <= d_r;
            sof_pending <= (state == WAIT_FRAME && state_n == ACTIVE) ? 1'b1 : push ? 1'b0 : sof_pending;
            pix_cnt     <= (hr_fall || vs_rise) ? '0 : (push && pix_cnt != LINE_FULL) ? pix_cnt + 1'b1 : pix_cnt;
            overflow    <= flag_clr ? 1'b0 : overflow | ovf_now;
            line_err    <= flag_clr ? 1'b0 : line_err | lerr_now;
            frame_cnt   <= frame_cnt + 16'((state == ACTIVE || state == DROP) && vs_rise);
        end
    end

    axis_sync_fifo #(.W($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .pop     (pop),
        .wdata   (wr),
        .rdata   (rd),
        .full    (full),
        .empty   (empty)
    );

    assign m_axis_video.tvalid = ~empty;
    assign m_axis_video.tdata  = empty ? '0 : rd.tdata;
    assign m_axis_video.tuser  = ~empty & rd.tuser;
    assign m_axis_video.tlast  = ~empty & rd.tlast;
endmodule

// File: tb/tb_dvp_rgb565_axis_capture.sv
// tb_dvp_rgb565_axis_capture: directed checks of pixel pairing, colour expansion, framing, backpressure and errors
module tb_dvp_rgb565_axis_capture;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        en_capture = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  din = '0;
    logic        overflow, line_err;
    logic [15:0] frame_cnt;
    int          checks = 0;
    int          passed = 0;
    logic [25:0] beats [$];

    logic [15:0] line_a [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    logic [15:0] line_b [4] = '{16'h0000, 16'h8410, 16'hF81F, 16'h07FF};
    logic [15:0] line_c [4] = '{16'h0841, 16'hFFE0, 16'h001F, 16'h7BEF};
    logic [25:0] exp_a  [4] = '{26'h2FF0000, 26'h00000FF, 26'h000FF00, 26'h1FFFFFF};
    logic [25:0] exp_a2 [4] = '{26'h0FF0000, 26'h00000FF, 26'h000FF00, 26'h1FFFFFF};
    logic [25:0] exp_b  [4] = '{26'h0000000, 26'h0848482, 26'h0FFFF00, 26'h100FFFF};
    logic [25:0] exp_c  [4] = '{26'h2080808, 26'h0FF00FF, 26'h000FF00, 26'h17B7B7D};

    dvp_rgb565_axis_capture_if bus ();

    dvp_rgb565_axis_capture #(.ACTIVE_W(4), .ACTIVE_H(2), .FIFO_DEPTH(4)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .en_capture   (en_capture),
        .vsync        (vsync),
        .href         (href),
        .din          (din),
        .m_axis_video (bus),
        .overflow     (overflow),
        .line_err     (line_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk)
        if (aresetn && bus.tvalid && bus.tready) beats.push_back({bus.tuser, bus.tlast, bus.tdata});

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        href = 1'b1;
        din = b;
        tick(1);
    endtask

    task automatic line(input logic [15:0] px [4], input int n);
        for (int i = 0; i < n; i++) begin
            put(px[i][15:8]);
            put(px[i][7:0]);
        end
        href = 1'b0;
        tick(3);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        tick(3);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        din = '0;
        en_capture = 1'b1;
        bus.tready = 1'b1;
        tick(2);
        aresetn = 1'b1;
        tick(1);
        beats.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", bus.tvalid); else passed++;
        checks++; if (bus.tdata !== 24'h0) $display("FAIL reset_tdata: got %h want 000000", bus.tdata); else passed++;
        checks++; if (bus.tuser !== 1'b0) $display("FAIL reset_tuser: got %b want 0", bus.tuser); else passed++;
        checks++; if (bus.tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", bus.tlast); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
        checks++; if (line_err !== 1'b0) $display("FAIL reset_line_err: got %b want 0", line_err); else passed++;
        checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
    endtask

    task automatic test_basic_frame();
        do_reset();
        frame_start();
        line(line_a, 4);
        line(line_b, 4);
        frame_end();
        tick(4);
        checks++; if (beats.size() !== 8) $display("FAIL basic_count: got %0d want 8", beats.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (beats[i] !== exp_a[i]) $display("FAIL basic_beat%0d: got %h want %h", i, beats[i], exp_a[i]); else passed++;
            checks++; if (beats[i+4] !== exp_b[i]) $display("FAIL basic_beat%0d: got %h want %h", i + 4, beats[i+4], exp_b[i]); else passed++;
        end
        checks++; if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); else passed++;
        checks++; if (line_err !== 1'b0) $display("FAIL basic_line_err: got %b want 0", line_err); else passed++;
    endtask

    task automatic test_colour();
        do_reset();
        frame_start();
        line(line_c, 4);
        tick(4);
        checks++; if (beats.size() !== 4) $display("FAIL colour_count: got %0d want 4", beats.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (beats[i] !== exp_c[i]) $display("FAIL colour_beat%0d: got %h want %h", i, beats[i], exp_c[i]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] held;
        logic        seen, unstable;
        do_reset();
        frame_start();
        bus.tready = 1'b0;
        held = '0;
        seen = 1'b0;
        unstable = 1'b0;
        fork
            line(line_a, 4);
            repeat (12) begin
                @(negedge aclk);
                if (bus.tvalid) begin
                    if (!seen) begin
                        held = {bus.tuser, bus.tlast, bus.tdata};
                        seen = 1'b1;
                    end else if ({bus.tuser, bus.tlast, bus.tdata} !== held) unstable = 1'b1;
                end
            end
        join
        tick(1);
        bus.tready = 1'b1;
        tick(8);
        checks++; if (held !== exp_a[0]) $display("FAIL bp_held: got %h want %h", held, exp_a[0]); else passed++;
        checks++; if (unstable !== 1'b0) $display("FAIL bp_stable: got %b want 0", unstable); else passed++;
        checks++; if (beats.size() !== 4) $display("FAIL bp_count: got %0d want 4", beats.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (beats[i] !== exp_a[i]) $display("FAIL bp_beat%0d: got %h want %h", i, beats[i], exp_a[i]); else passed++;
        end
        checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        bus.tready = 1'b0;
        frame_start();
        line(line_a, 4);
        line(line_b, 4);
        frame_end();
        bus.tready = 1'b1;
        tick(8);
        checks++; if (beats.size() !== 4) $display("FAIL ovf_count: got %0d want 4", beats.size()); else passed++;
        checks++; if (beats[0] !== exp_a[0]) $display("FAIL ovf_first: got %h want %h", beats[0], exp_a[0]); else passed++;
        checks++; if (beats[3] !== exp_a[3]) $display("FAIL ovf_last: got %h want %h", beats[3], exp_a[3]); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passed++;
        checks++; if (frame_cnt !== 16'd1) $display("FAIL ovf_frame_cnt: got %0d want 1", frame_cnt); else passed++;
        beats.delete();
        frame_start();
        line(line_a, 4);
        frame_end();
        tick(4);
        checks++; if (beats.size() !== 4) $display("FAIL ovf_next_count: got %0d want 4", beats.size()); else passed++;
        checks++; if (beats[0] !== exp_a[0]) $display("FAIL ovf_next_sof: got %h want %h", beats[0], exp_a[0]); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
        checks++; if (frame_cnt !== 16'd2) $display("FAIL ovf_frame_cnt2: got %0d want 2", frame_cnt); else passed++;
    endtask

    task automatic test_short_line();
        do_reset();
        frame_start();
        line(line_a, 3);
        tick(4);
        checks++; if (beats.size() !== 3) $display("FAIL short_count: got %0d want 3", beats.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (beats[i] !== exp_a[i]) $display("FAIL short_beat%0d: got %h want %h", i, beats[i], exp_a[i]); else passed++;
        end
        checks++; if (line_err !== 1'b1) $display("FAIL short_line_err: got %b want 1", line_err); else passed++;
        frame_start();
        line(line_a, 4);
        checks++; if (line_err !== 1'b1) $display("FAIL short_sticky: got %b want 1", line_err); else passed++;
        beats.delete();
        put(8'hF8);
        put(8'h00);
        put(8'h07);
        href = 1'b0;
        tick(4);
        checks++; if (beats.size() !== 1) $display("FAIL odd_count: got %0d want 1", beats.size()); else passed++;
        checks++; if (beats[0] !== 26'h0FF0000) $display("FAIL odd_beat: got %h want 0FF0000", beats[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.tready = 1'b0;
        frame_start();
        line(line_a, 1);
        put(8'hF8);
        put(8'h00);
        put(8'h07);
        checks++; if (line_err !== 1'b1) $display("FAIL mid_pre_line_err: got %b want 1", line_err); else passed++;
        checks++; if (bus.tvalid !== 1'b1) $display("FAIL mid_pre_tvalid: got %b want 1", bus.tvalid); else passed++;
        aresetn = 1'b0;
        #1;
        checks++; if (bus.tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b want 0", bus.tvalid); else passed++;
        checks++; if (line_err !== 1'b0) $display("FAIL mid_line_err: got %b want 0", line_err); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL mid_overflow: got %b want 0", overflow); else passed++;
        tick(2);
        aresetn = 1'b1;
        bus.tready = 1'b1;
        beats.delete();
        put(8'hE0);
        put(8'h00);
        put(8'h1F);
        href = 1'b0;
        tick(3);
        line(line_a, 4);
        tick(4);
        checks++; if (beats.size() !== 0) $display("FAIL mid_no_beats: got %0d want 0", beats.size()); else passed++;
        frame_end();
        frame_start();
        line(line_a, 4);
        tick(4);
        checks++; if (beats.size() !== 4) $display("FAIL mid_next_count: got %0d want 4", beats.size()); else passed++;
        checks++; if (beats[0] !== exp_a[0]) $display("FAIL mid_next_sof: got %h want %h", beats[0], exp_a[0]); else passed++;
    endtask

    task automatic test_en_drop();
        do_reset();
        frame_start();
        line(line_a, 4);
        en_capture = 1'b0;
        line(line_a, 4);
        frame_end();
        tick(4);
        checks++; if (beats.size() !== 8) $display("FAIL en_count: got %0d want 8", beats.size()); else passed++;
        checks++; if (beats[4] !== exp_a2[0]) $display("FAIL en_line2_first: got %h want %h", beats[4], exp_a2[0]); else passed++;
        checks++; if (beats[7] !== exp_a2[3]) $display("FAIL en_line2_last: got %h want %h", beats[7], exp_a2[3]); else passed++;
        checks++; if (frame_cnt !== 16'd1) $display("FAIL en_frame_cnt: got %0d want 1", frame_cnt); else passed++;
        frame_start();
        line(line_a, 4);
        frame_end();
        tick(4);
        checks++; if (beats.size() !== 8) $display("FAIL en_stopped: got %0d want 8", beats.size()); else passed++;
        checks++; if (frame_cnt !== 16'd1) $display("FAIL en_frame_cnt2: got %0d want 1", frame_cnt); else passed++;
    endtask

    initial begin
        bus.tready = 1'b1;
        test_reset();
        test_basic_frame();
        test_colour();
        test_backpressure();
        test_overflow();
        test_short_line();
        test_reset_mid();
        test_en_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
